// File: rtl/mvm_pkg.sv
// Shared types and helpers for the matrix-vector multiplier.
package mvm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_M,
    LOAD_V,
    COMPUTE,
    OUTPUT
  } state_t;

  function automatic int acc_width(input int k, input int b);
    return 2 * b + $clog2(k);
  endfunction

  // Clip v into the signed range of 'width' bits.
  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic sat_hit(input logic signed [63:0] v, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/mvm_dot_slice.sv
// P parallel signed multipliers with a registered product stage, reduced
// combinationally into one accumulator-width partial sum.
module mvm_dot_slice
  import mvm_pkg::*;
#(
  parameter int K = 16,
  parameter int B = 8,
  parameter int P = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [P*B-1:0]                     a_lanes,
  input  logic [P*B-1:0]                     x_lanes,
  output logic signed [acc_width(K, B)-1:0] sum
);

  localparam int W  = acc_width(K, B);
  localparam int PW = 2 * B;

  logic [P*PW-1:0] prod_flat;

  genvar gi;
  generate
    for (gi = 0; gi < P; gi++) begin : g_lane
      logic signed [B-1:0]  a_l;
      logic signed [B-1:0]  x_l;
      logic signed [PW-1:0] prod_reg;

      assign a_l = a_lanes[gi*B +: B];
      assign x_l = x_lanes[gi*B +: B];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) prod_reg <= '0;
        else       prod_reg <= PW'(a_l) * PW'(x_l);
      end

      assign prod_flat[gi*PW +: PW] = prod_reg;
    end
  endgenerate

  always_comb begin
    sum = '0;
    for (int i = 0; i < P; i++) begin
      sum = sum + W'(signed'(prod_flat[i*PW +: PW]));
    end
  end

endmodule

// File: rtl/mvm_param.sv
// K x K by K signed matrix-vector multiplier with P MAC lanes and saturated output.
// Optional feature: define MVM_RELU_EN to clamp negative results to zero.
module mvm_param
  import mvm_pkg::*;
#(
  parameter int K = 16,
  parameter int B = 8,
  parameter int P = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           loadMatrix,
  input  logic           loadVector,
  input  logic           start,
  input  logic           in_valid,
  input  logic [B-1:0]   data_in,
  output logic           done,
  output logic           busy,
  output logic           out_valid,
  output logic           out_sat,
  output logic [2*B-1:0] data_out
);

  localparam int CH = K / P;
  localparam int N  = K * K / P;
  localparam int W  = acc_width(K, B);
  localparam int OW = 2 * B;
  localparam int MA = $clog2(N);
  localparam int VA = (CH > 1) ? $clog2(CH) : 1;
  localparam int RW = $clog2(K);
  localparam int LW = $clog2(K * K);

  state_t              state;
  logic [LW-1:0]       ld_idx;
  logic                matrix_loaded;
  logic                vector_loaded;
  logic [RW-1:0]       rd_row;
  logic [VA-1:0]       rd_chunk;
  logic [RW-1:0]       wr_row;
  logic [RW:0]         out_idx;
  logic                issuing;
  logic                v1, last1, v2, last2;
  logic signed [W-1:0] acc;
  logic signed [W-1:0] tree_sum;
  logic signed [W-1:0] row_sum;
  logic                go;
  logic                issue;
  logic [MA-1:0]       mat_raddr;
  logic [MA-1:0]       ld_maddr;
  logic [VA-1:0]       ld_vaddr;
  logic [P*B-1:0]      a_lanes;
  logic [P*B-1:0]      x_lanes;
  logic [OW:0]         res_word;
  logic [OW:0]         res_mem [K];

  assign go    = (state == IDLE) && !loadMatrix && !loadVector && start
                 && matrix_loaded && vector_loaded;
  assign issue = go || ((state == COMPUTE) && issuing);

  // Lane l of chunk c in row i is A[i*K + c*P + l], stored in bank l at i*CH + c.
  assign mat_raddr = MA'(int'(rd_row) * CH + int'(rd_chunk));
  assign ld_maddr  = MA'(int'(ld_idx) / P);
  assign ld_vaddr  = VA'(int'(ld_idx) / P);

  genvar gi;
  generate
    for (gi = 0; gi < P; gi++) begin : g_bank
      logic signed [B-1:0] mat_mem [N];
      logic signed [B-1:0] vec_mem [CH];
      logic signed [B-1:0] a_rd;
      logic signed [B-1:0] x_rd;

      always_ff @(posedge clk) begin
        if (state == LOAD_M && in_valid && (int'(ld_idx) % P) == gi)
          mat_mem[ld_maddr] <= data_in;
        if (state == LOAD_V && in_valid && (int'(ld_idx) % P) == gi)
          vec_mem[ld_vaddr] <= data_in;
        a_rd <= mat_mem[mat_raddr];
        x_rd <= vec_mem[rd_chunk];
      end

      assign a_lanes[gi*B +: B] = a_rd;
      assign x_lanes[gi*B +: B] = x_rd;
    end
  endgenerate

  mvm_dot_slice #(.K(K), .B(B), .P(P)) u_slice (
    .clk     (clk),
    .reset   (reset),
    .a_lanes (a_lanes),
    .x_lanes (x_lanes),
    .sum     (tree_sum)
  );

  assign row_sum = acc + tree_sum;

  always_comb begin
    res_word = {sat_hit(64'(row_sum), OW), OW'(sat_clip(64'(row_sum), OW))};
`ifdef MVM_RELU_EN
    if (row_sum < 0) res_word = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (v2 && last2) res_mem[wr_row] <= res_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ld_idx        <= '0;
      matrix_loaded <= 1'b0;
      vector_loaded <= 1'b0;
      rd_row        <= '0;
      rd_chunk      <= '0;
      wr_row        <= '0;
      out_idx       <= '0;
      issuing       <= 1'b0;
      v1            <= 1'b0;
      last1         <= 1'b0;
      v2            <= 1'b0;
      last2         <= 1'b0;
      acc           <= '0;
      done          <= 1'b0;
      busy          <= 1'b0;
      out_valid     <= 1'b0;
      out_sat       <= 1'b0;
      data_out      <= '0;
    end else begin
      done <= 1'b0;

      // Read issue: one P-wide chunk per cycle, rows in order.
      if (issue) begin
        if (rd_chunk == VA'(CH - 1)) begin
          rd_chunk <= '0;
          if (rd_row == RW'(K - 1)) begin
            rd_row  <= '0;
            issuing <= 1'b0;
          end else begin
            rd_row  <= rd_row + 1'b1;
            issuing <= 1'b1;
          end
        end else begin
          rd_chunk <= rd_chunk + 1'b1;
          issuing  <= 1'b1;
        end
      end

      v1    <= issue;
      last1 <= issue && (rd_chunk == VA'(CH - 1));
      v2    <= v1;
      last2 <= last1;

      if (v2) begin
        if (last2) begin
          acc    <= '0;
          wr_row <= (wr_row == RW'(K - 1)) ? '0 : wr_row + 1'b1;
        end else begin
          acc <= row_sum;
        end
      end

      case (state)
        IDLE: begin
          ld_idx <= '0;
          if (loadMatrix) begin
            state <= LOAD_M;
            busy  <= 1'b1;
          end else if (loadVector) begin
            state <= LOAD_V;
            busy  <= 1'b1;
          end else if (go) begin
            state <= COMPUTE;
            busy  <= 1'b1;
          end
        end
        LOAD_M: begin
          if (in_valid) begin
            if (ld_idx == LW'(K * K - 1)) begin
              state         <= IDLE;
              busy          <= 1'b0;
              matrix_loaded <= 1'b1;
              ld_idx        <= '0;
            end else begin
              ld_idx <= ld_idx + 1'b1;
            end
          end
        end
        LOAD_V: begin
          if (in_valid) begin
            if (ld_idx == LW'(K - 1)) begin
              state         <= IDLE;
              busy          <= 1'b0;
              vector_loaded <= 1'b1;
              ld_idx        <= '0;
            end else begin
              ld_idx <= ld_idx + 1'b1;
            end
          end
        end
        COMPUTE: begin
          out_idx <= '0;
          if (v2 && last2 && wr_row == RW'(K - 1)) state <= OUTPUT;
        end
        OUTPUT: begin
          if (out_idx == (RW + 1)'(K)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
            data_out  <= '0;
            out_idx   <= '0;
          end else begin
            data_out  <= res_mem[out_idx[RW-1:0]][OW-1:0];
            out_sat   <= res_mem[out_idx[RW-1:0]][OW];
            out_valid <= 1'b1;
            done      <= (out_idx == '0);
            out_idx   <= out_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_param.sv
// Directed bench for mvm_param at K=4, B=8, P=2 with a reference model and literal pins.
module tb_mvm_param;

  localparam int K = 4;
  localparam int B = 8;
  localparam int P = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           loadMatrix;
  logic           loadVector;
  logic           start;
  logic           in_valid;
  logic [B-1:0]   data_in;
  logic           done;
  logic           busy;
  logic           out_valid;
  logic           out_sat;
  logic [2*B-1:0] data_out;

  mvm_param #(.K(K), .B(B), .P(P)) dut (
    .clk        (clk),
    .reset      (reset),
    .loadMatrix (loadMatrix),
    .loadVector (loadVector),
    .start      (start),
    .in_valid   (in_valid),
    .data_in    (data_in),
    .done       (done),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_sat    (out_sat),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int ma [K*K];
  int mx [K];

  typedef struct {
    int y;
    bit sat;
    bit first;
  } exp_t;
  exp_t exp_q [$];

  int got_y [K];
  int got_sat [K];
  int got_n = 0;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: plain dot products, clipped to 16 bits, optional ReLU.
  function automatic void push_expect();
    for (int i = 0; i < K; i++) begin
      int s;
      bit st;
      s  = 0;
      st = 1'b0;
      for (int j = 0; j < K; j++) s += ma[i*K+j] * mx[j];
      if (s > 32767) begin
        s = 32767;
        st = 1'b1;
      end else if (s < -32768) begin
        s = -32768;
        st = 1'b1;
      end
`ifdef MVM_RELU_EN
      if (s < 0) begin
        s = 0;
        st = 1'b0;
      end
`endif
      exp_q.push_back(exp_t'{y: s, sat: st, first: (i == 0)});
    end
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("y", int'($signed(data_out)), e.y);
          check("out_sat", int'(out_sat), int'(e.sat));
          check("done_with_y0", int'(done), int'(e.first));
          if (got_n < K) begin
            got_y[got_n]   = int'($signed(data_out));
            got_sat[got_n] = int'(out_sat);
            got_n++;
          end
        end
      end else begin
        check("idle_outputs", int'({done, out_sat, data_out}), 0);
      end
    end
  end

  task automatic load_mat(input bit gaps);
    @(negedge clk) loadMatrix = 1'b1;
    @(negedge clk) loadMatrix = 1'b0;
    check("busy_in_load_m", int'(busy), 1);
    for (int i = 0; i < K*K; i++) begin
      in_valid = 1'b1;
      data_in  = B'(ma[i]);
      @(negedge clk);
      if (gaps) begin
        in_valid = 1'b0;
        data_in  = 8'h5a;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    check("busy_after_load_m", int'(busy), 0);
  endtask

  task automatic load_vec(input bit gaps);
    @(negedge clk) loadVector = 1'b1;
    @(negedge clk) loadVector = 1'b0;
    check("busy_in_load_v", int'(busy), 1);
    for (int i = 0; i < K; i++) begin
      in_valid = 1'b1;
      data_in  = B'(mx[i]);
      @(negedge clk);
      if (gaps) begin
        in_valid = 1'b0;
        data_in  = 8'ha5;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    check("busy_after_load_v", int'(busy), 0);
  endtask

  task automatic run_mvm();
    int lat;
    int n;
    push_expect();
    got_n = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    lat = 0;
    while (!done && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("done_latency", lat, K*K/P + 2);
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("busy_drops", int'(busy), 0);
    check("result_count", got_n, K);
    check("pending_expect", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic pin(input string tag, input int y0, input int y1, input int y2,
                     input int y3, input int s);
    int lit [K];
    lit[0] = y0; lit[1] = y1; lit[2] = y2; lit[3] = y3;
    for (int i = 0; i < K; i++) begin
      check({tag, "_y"}, got_y[i], lit[i]);
      check({tag, "_sat"}, got_sat[i], s);
    end
  endtask

  task automatic set_identity(input int sign);
    for (int i = 0; i < K*K; i++) ma[i] = ((i / K) == (i % K)) ? sign : 0;
    for (int j = 0; j < K; j++) mx[j] = j + 1;
  endtask

  initial begin
    int seen_done;
    reset = 1'b1;
    loadMatrix = 1'b0;
    loadVector = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    data_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sat", int'(out_sat), 0);
    check("rst_data_out", int'(data_out), 0);
    reset = 1'b0;
    @(negedge clk);

    // Identity times (1,2,3,4)
    set_identity(1);
    load_mat(1'b0);
    load_vec(1'b0);
    run_mvm();
    pin("ident", 1, 2, 3, 4, 0);

    // Vector first, then all-2 matrix against all-1 vector
    for (int j = 0; j < K; j++) mx[j] = 1;
    load_vec(1'b0);
    for (int i = 0; i < K*K; i++) ma[i] = 2;
    load_mat(1'b0);
    run_mvm();
    pin("twos", 8, 8, 8, 8, 0);

    // Positive and negative overflow
    for (int i = 0; i < K*K; i++) ma[i] = 127;
    for (int j = 0; j < K; j++) mx[j] = 127;
    load_mat(1'b0);
    load_vec(1'b0);
    run_mvm();
    pin("sat_pos", 32767, 32767, 32767, 32767, 1);
    for (int i = 0; i < K*K; i++) ma[i] = -128;
    load_mat(1'b0);
    run_mvm();
    pin("sat_neg", -32768, -32768, -32768, -32768, 1);

    // Identity again with in_valid gaps, then a rerun without reload
    set_identity(1);
    load_mat(1'b1);
    load_vec(1'b1);
    run_mvm();
    pin("gaps", 1, 2, 3, 4, 0);
    run_mvm();
    pin("rerun", 1, 2, 3, 4, 0);

    // Negated identity
    set_identity(-1);
    load_mat(1'b0);
    run_mvm();
`ifdef MVM_RELU_EN
    pin("neg_ident", 0, 0, 0, 0, 0);
`else
    check("neg_ident_y0", got_y[0], -1);
    check("neg_ident_y1", got_y[1], -2);
    check("neg_ident_y2", got_y[2], -3);
    check("neg_ident_y3", got_y[3], -4);
`endif

    // Reset three cycles into COMPUTE aborts and drops the loaded flags
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    @(negedge clk) reset = 1'b0;
    seen_done = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done) seen_done++;
      @(negedge clk);
    end
    check("abort_no_done", seen_done, 0);
    check("abort_start_ignored_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mvm_param.md
MVM_PARAM -- requirements
Module: mvm_param

Interface
REQ-001 Parameter K, default 16, matrix dimension (K x K matrix, K-element vector); K >= 2.
REQ-002 Parameter B, default 8, signed element width of matrix and vector data.
REQ-003 Parameter P, default 1, parallel MAC lanes; K divisible by P.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 loadMatrix  input  1  one-cycle pulse opening a matrix load of K*K elements.
REQ-007 loadVector  input  1  one-cycle pulse opening a vector load of K elements.
REQ-008 start  input  1  one-cycle pulse launching the multiply.
REQ-009 in_valid  input  1  data_in qualifier during loads.
REQ-010 data_in  input  B  signed load data: matrix row-major A[i*K+j], vector x[j].
REQ-011 done  output  1  one-cycle pulse marking the first result cycle.
REQ-012 busy  output  1  high in LOAD_M, LOAD_V, COMPUTE, OUTPUT.
REQ-013 out_valid  output  1  high while data_out carries a result.
REQ-014 out_sat  output  1  high when the current data_out value was clipped.
REQ-015 data_out  output  2*B  signed result y[i].

Function
REQ-016 States IDLE, LOAD_M, LOAD_V, COMPUTE, OUTPUT; only IDLE accepts loadMatrix, loadVector or start; these inputs are ignored in any other state.
REQ-017 IDLE->LOAD_M on loadMatrix; elements are captured on the following cycles whenever in_valid=1; after the K*K-th capture, return to IDLE and set matrix_loaded.
REQ-018 IDLE->LOAD_V on loadVector, same rules, K elements, sets vector_loaded.
REQ-019 Simultaneous loadMatrix and loadVector in IDLE: loadMatrix wins and loadVector is dropped.
REQ-020 Load order is free, and data may carry in_valid gaps of any length.
REQ-021 start in IDLE is accepted only when matrix_loaded and vector_loaded are both set; otherwise it is ignored.
REQ-022 Loaded data persists after OUTPUT, so a later start recomputes the same data without a reload.
REQ-023 COMPUTE processes rows in order; each row takes K/P cycles of P products, a registered multiply stage and an adder tree into a 2*B+clog2(K) accumulator.
REQ-024 done and out_valid rise exactly K*K/P+2 cycles after the cycle in which start was sampled.
REQ-025 OUTPUT drives y[0]..y[K-1] on K consecutive cycles with out_valid=1; done is high only with y[0]; the block then returns to IDLE.
REQ-026 Each y[i] is saturated to the signed 2*B range; out_sat=1 in exactly the cycles where clipping occurred.
REQ-027 Outside OUTPUT, data_out=0, out_valid=0 and out_sat=0.

Reset
REQ-028 reset forces IDLE and sets done=busy=out_valid=out_sat=0 and data_out=0.
REQ-029 reset clears matrix_loaded and vector_loaded; RAM contents are not cleared.
REQ-030 reset during any load, COMPUTE or OUTPUT aborts the operation, and no done follows.

Configuration
REQ-031 With MVM_RELU_EN defined, negative y[i] are output as 0 with out_sat=0, and positive overflow still saturates.
REQ-032 Without MVM_RELU_EN, signed results pass through unchanged apart from saturation.

Structure
REQ-033 Package mvm_pkg holds the state enum, the accumulator-width function (2*B+clog2(K)) and the saturation helper function.
REQ-034 Sub-module mvm_dot_slice implements the P multipliers, the pipeline register and the adder tree; mvm_param instantiates it once.

Verification (K=4, B=8, P=2)
REQ-035 A=identity, x=(1,2,3,4), start -> y=(1,2,3,4), done 10 cycles after start, out_sat=0 throughout.
REQ-036 Vector loaded before matrix, A all 2, x all 1 -> y=(8,8,8,8).
REQ-037 A all 127, x all 127 -> y=32767 four times with out_sat=1; A all -128, x all 127 -> y=-32768 four times with out_sat=1.
REQ-038 Rerun REQ-035 with in_valid toggling 1,0 on alternate cycles during both loads -> identical results.
REQ-039 reset pulsed 3 cycles into COMPUTE -> busy=0 and no done; a following start without reload is ignored, with no done within 20 cycles.
REQ-040 A=-identity, x=(1,2,3,4) -> y=(0,0,0,0) with MVM_RELU_EN defined; y=(-1,-2,-3,-4) without it.
